lcm_gcd_host: RTL and testbench
===============================

Name: lcm_gcd_host

Overview:
Initiator-side sequencer for the LCM/GCD core's shared operand bus. Accepts an operand pair plus a mode over a valid/ready request channel. Serialises the pair onto the core's single data bus with a start strobe, waits for the core's done, and returns the result over a valid/ready response channel. Sits between the system bus/register front end and the LCM/GCD core, so that no caller ever drives the core's load sequence directly.

Parameters:
DATA_WIDTH, 16, width of operands and result (matches core).
TIMEOUT_CYCLES, 1024, maximum WAIT cycles before error (used only with LCM_GCD_TIMEOUT_EN).

Ports:
clk  input  1  rising-edge clock, shared with core
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_a  input  DATA_WIDTH  first operand
req_b  input  DATA_WIDTH  second operand
req_mode  input  1  1 = LCM, 0 = GCD
core_start  output  1  one-cycle start strobe to core
core_mode  output  1  drives core LCM_GCD select
core_data  output  DATA_WIDTH  drives core data_input
core_done  input  1  core completion flag (level)
core_result  input  DATA_WIDTH  core LCM_GCD_out
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_result  output  DATA_WIDTH  computed value (0 on error)
rsp_error  output  1  zero operand or timeout
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE. Outputs in reset: req_ready=1, core_start=0, core_mode=0, core_data=0, rsp_valid=0, rsp_result=0, rsp_error=0, busy=0. Reset wins over every other event, including mid-WAIT. The core is not reset by this block; the next request re-loads it.
- States: IDLE, SEND_A, SEND_B, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge t, latch a, b and mode.
  - If a==0 or b==0: go to RESP with rsp_error=1 and rsp_result=0. rsp_valid is high in cycle t+1. The core is never started, because the subtractive GCD does not terminate on zero.
  - Otherwise go to SEND_A.
- SEND_A (cycle t+1): core_start=1, core_data=a, core_mode=mode. Go to SEND_B.
- SEND_B (cycle t+2): core_start=0, core_data=b. Go to WAIT.
- WAIT (from cycle t+3):
  - core_data=0; core_mode held.
  - core_done high in cycle n: capture core_result, go to RESP. rsp_valid is high in cycle n+1 with rsp_error=0.
  - core_done already high in the first WAIT cycle counts.
- RESP:
  - rsp_valid=1. rsp_result and rsp_error are held stable until rsp_valid&&rsp_ready.
  - On handshake: go to IDLE. req_ready rises the following cycle; there is no request/response overlap.
- req_ready=0 in all states except IDLE. A request presented while busy is ignored until IDLE.
- core_mode changes only on entry to SEND_A, and stays stable through SEND_A..WAIT.
- core_start is exactly one cycle wide per request.
- Results are passed through unmodified; no width extension (the core's DATA_WIDTH result is truncated as the core defines it).

Optional Feature:
LCM_GCD_TIMEOUT_EN
- Defined:
  - A WAIT-cycle counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT.
  - If the counter reaches TIMEOUT_CYCLES without core_done: go to RESP with rsp_error=1, rsp_result=0.
  - core_done and timeout in the same cycle: done wins.
- Not defined:
  - No counter logic; WAIT lasts until core_done.
  - rsp_error asserts only for zero operands.

Test Plan:
- GCD(48,18): req mode=0 accepted at t -> core_start high at t+1 with core_data=48; core_data=18 at t+2; core_done with result 6 -> rsp_valid next cycle, rsp_result=6, rsp_error=0.
- LCM(4,6): mode=1 -> core_mode=1 held through WAIT, rsp_result=12.
- Zero operand (a=0, b=9) -> core_start never asserts; rsp_valid at t+1, rsp_error=1, rsp_result=0.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid -> result held stable and req_ready=0 throughout; a new req_valid meanwhile is not accepted until the cycle after the handshake.
- Timeout (LCM_GCD_TIMEOUT_EN, TIMEOUT_CYCLES=8): core_done never asserts -> rsp_error=1 after 8 WAIT cycles. Without the macro, the block stays in WAIT with busy=1.
- Reset in WAIT: assert reset one cycle -> all outputs at reset values next cycle, req_ready=1. A following GCD(7,21) returns 7.

Source files
------------

// File: rtl/lcm_gcd_host.sv
// lcm_gcd_host: accepts an operand pair, serialises it onto the LCM/GCD core bus, returns the result. Start strobe 1 cycle after accept,
// response the cycle after core_done, held until rsp_ready (no request overlap). Define LCM_GCD_TIMEOUT_EN to bound the WAIT state.
module lcm_gcd_host #(
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_WIDTH-1:0] req_a,
   input  logic [DATA_WIDTH-1:0] req_b,
   input  logic                  req_mode,
   output logic                  core_start,
   output logic                  core_mode,
   output logic [DATA_WIDTH-1:0] core_data,
   input  logic                  core_done,
   input  logic [DATA_WIDTH-1:0] core_result,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_result,
   output logic                  rsp_error,
   output logic                  busy
);

   typedef enum logic [2:0] {S_IDLE, S_SEND_A, S_SEND_B, S_WAIT, S_RESP} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] b_hold;

`ifdef LCM_GCD_TIMEOUT_EN
   localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] wait_cnt;
   logic          timed_out;

   // Counts completed WAIT cycles; the last allowed cycle is index TIMEOUT_CYCLES-1.
   assign timed_out = (wait_cnt == LAST);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         b_hold     <= '0;
         req_ready  <= 1'b1;
         core_start <= 1'b0;
         core_mode  <= 1'b0;
         core_data  <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_error  <= 1'b0;
         busy       <= 1'b0;
`ifdef LCM_GCD_TIMEOUT_EN
         wait_cnt   <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  b_hold    <= req_b;
                  // A zero operand would hang the subtractive GCD, so the core is never started.
                  if (req_a == '0 || req_b == '0) begin
                     state      <= S_RESP;
                     rsp_valid  <= 1'b1;
                     rsp_error  <= 1'b1;
                     rsp_result <= '0;
                  end else begin
                     state      <= S_SEND_A;
                     core_start <= 1'b1;
                     core_data  <= req_a;
                     core_mode  <= req_mode;
                  end
               end
            end
            S_SEND_A: begin
               core_start <= 1'b0;
               core_data  <= b_hold;
               state      <= S_SEND_B;
            end
            S_SEND_B: begin
               core_data <= '0;
               state     <= S_WAIT;
`ifdef LCM_GCD_TIMEOUT_EN
               wait_cnt  <= '0;
`endif
            end
            S_WAIT: begin
               if (core_done) begin
                  rsp_result <= core_result;
                  rsp_error  <= 1'b0;
                  rsp_valid  <= 1'b1;
                  state      <= S_RESP;
               end
`ifdef LCM_GCD_TIMEOUT_EN
               else if (timed_out) begin
                  rsp_result <= '0;
                  rsp_error  <= 1'b1;
                  rsp_valid  <= 1'b1;
                  state      <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt + CW'(1);
               end
`endif
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
               busy      <= 1'b0;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcm_gcd_host.sv
// tb_lcm_gcd_host: plays the LCM/GCD core and the requester/consumer; results checked against an arithmetic GCD/LCM model.
// Covers directed cases, randomised requests, backpressure, zero operands, timeout (when LCM_GCD_TIMEOUT_EN) and reset in WAIT.
module tb_lcm_gcd_host;
   localparam int DW = 16;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid;
   logic          req_ready;
   logic [DW-1:0] req_a;
   logic [DW-1:0] req_b;
   logic          req_mode;
   logic          core_start;
   logic          core_mode;
   logic [DW-1:0] core_data;
   logic          core_done;
   logic [DW-1:0] core_result;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_result;
   logic          rsp_error;
   logic          busy;

   int n_cmp = 0;
   int n_bad = 0;

   lcm_gcd_host #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_mode(req_mode),
      .core_start(core_start), .core_mode(core_mode), .core_data(core_data),
      .core_done(core_done), .core_result(core_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_error(rsp_error), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Plain Euclid GCD; LCM = a*b/gcd truncated to DW bits like the core.
   function automatic logic [DW-1:0] ref_calc(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic mode);
      longint unsigned x, y, t, p;
      x = longint'(a);
      y = longint'(b);
      if (x == 0 || y == 0) return '0;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      if (!mode) return DW'(x);
      p = (longint'(a) * longint'(b)) / x;
      return DW'(p);
   endfunction

   task automatic chk_reset_vals();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_core_start", core_start, 0);
      chk("rst_core_mode", core_mode, 0);
      chk("rst_core_data", core_data, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_error", rsp_error, 0);
      chk("rst_busy", busy, 0);
   endtask

   // Present a request and return in cycle t+1 (first cycle after the accepting edge).
   task automatic accept(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic mode);
      int guard = 0;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_mode  = mode;
      @(negedge clk);
      req_valid = 1'b0;
      chk("req_ready_busy", req_ready, 0);
      chk("busy_after_accept", busy, 1);
   endtask

   // Checks SEND_A/SEND_B, captures what the core would load, returns in the first WAIT cycle.
   task automatic send_phase(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic mode,
                             output logic [DW-1:0] sa, output logic [DW-1:0] sb, output logic sm);
      chk("send_a_start", core_start, 1);
      chk("send_a_data", core_data, 32'(a));
      chk("send_a_mode", core_mode, 32'(mode));
      sa = core_data;
      sm = core_mode;
      @(negedge clk);
      chk("send_b_start", core_start, 0);
      chk("send_b_data", core_data, 32'(b));
      chk("send_b_mode", core_mode, 32'(mode));
      sb = core_data;
      @(negedge clk);
   endtask

   // Current cycle has rsp_valid high; hold backpressure, poke an intruder request, then handshake.
   task automatic finish_rsp(input logic [DW-1:0] exp_res, input logic exp_err, input int hold);
      for (int i = 0; i < hold; i++) begin
         rsp_ready = 1'b0;
         if (i == 1) begin
            req_valid = 1'b1;
            req_a     = DW'(5);
            req_b     = DW'(10);
            req_mode  = 1'b0;
         end
         @(negedge clk);
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_result", rsp_result, 32'(exp_res));
         chk("bp_rsp_error", rsp_error, 32'(exp_err));
         chk("bp_req_ready", req_ready, 0);
         chk("bp_core_start", core_start, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("hs_rsp_valid", rsp_valid, 0);
      chk("hs_req_ready", req_ready, 1);
      chk("hs_busy", busy, 0);
      chk("hs_core_start", core_start, 0);
      req_valid = 1'b0;
   endtask

   task automatic run_req(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic mode,
                          input int lat, input int hold);
      logic [DW-1:0] exp_res, sa, sb;
      logic          sm;
      exp_res = ref_calc(a, b, mode);
      accept(a, b, mode);
      if (a == '0 || b == '0) begin
         chk("zero_no_start", core_start, 0);
         chk("zero_rsp_valid", rsp_valid, 1);
         chk("zero_rsp_error", rsp_error, 1);
         chk("zero_rsp_result", rsp_result, 0);
         finish_rsp('0, 1'b1, hold);
      end else begin
         send_phase(a, b, mode, sa, sb, sm);
         for (int i = 0; i < lat; i++) begin
            chk("wait_data", core_data, 0);
            chk("wait_mode", core_mode, 32'(mode));
            chk("wait_rsp_valid", rsp_valid, 0);
            @(negedge clk);
         end
         core_done   = 1'b1;
         core_result = ref_calc(sa, sb, sm);
         @(negedge clk);
         core_done   = 1'b0;
         core_result = DW'($urandom);
         chk("rsp_valid", rsp_valid, 1);
         chk("rsp_error", rsp_error, 0);
         chk("rsp_result", rsp_result, 32'(exp_res));
         chk("rsp_no_start", core_start, 0);
         finish_rsp(exp_res, 1'b0, hold);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] ra, rb, sa, sb;
      logic          sm;
      int            stuck;
      reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_mode = 1'b0;
      core_done = 1'b0; core_result = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals();
      reset = 1'b0;
      @(negedge clk);

      run_req(DW'(48), DW'(18), 1'b0, 3, 0);
      run_req(DW'(4),  DW'(6),  1'b1, 1, 0);
      run_req(DW'(0),  DW'(9),  1'b0, 0, 1);
      run_req(DW'(48), DW'(18), 1'b0, 0, 5);
      run_req(DW'(7),  DW'(0),  1'b1, 0, 0);
      run_req(DW'(1000), DW'(999), 1'b1, 2, 2);

      for (int k = 0; k < 30; k++) begin
         ra = ($urandom_range(0, 12) == 0) ? '0 : DW'($urandom_range(1, 2000));
         rb = ($urandom_range(0, 12) == 0) ? '0 : DW'($urandom_range(1, 2000));
         run_req(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)));
      end

`ifdef LCM_GCD_TIMEOUT_EN
      accept(DW'(9), DW'(6), 1'b0);
      send_phase(DW'(9), DW'(6), 1'b0, sa, sb, sm);
      for (int i = 0; i < TO; i++) begin
         chk("to_wait_valid", rsp_valid, 0);
         chk("to_wait_busy", busy, 1);
         @(negedge clk);
      end
      chk("to_rsp_valid", rsp_valid, 1);
      chk("to_rsp_error", rsp_error, 1);
      chk("to_rsp_result", rsp_result, 0);
      finish_rsp('0, 1'b1, 2);
      stuck = 3;
`else
      stuck = 40;
`endif

      // Core never finishes; reset while parked in WAIT.
      accept(DW'(9), DW'(6), 1'b1);
      send_phase(DW'(9), DW'(6), 1'b1, sa, sb, sm);
      for (int i = 0; i < stuck; i++) begin
         chk("stuck_busy", busy, 1);
         chk("stuck_rsp_valid", rsp_valid, 0);
         chk("stuck_req_ready", req_ready, 0);
         @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_reset_vals();
      run_req(DW'(7), DW'(21), 1'b0, 2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
